beam_sweep_ctrl: RTL and testbench
==================================

# beam_sweep_ctrl

Sequencer for the `beamformer` datapath during beam sweeping.
- Steps through `NUM_BEAMS` beam indices and, for each one, requests a weight load from the weight path.
- Integrates the magnitude of `dwell_len` beamformer output samples per beam.
- Reports the strongest beam at the end of the sweep.
- Sits between the control/MAC layer (start, dwell length) and the beamformer weight path and output stream.

## Interface
Parameters:
- `NUM_BEAMS`, 8, number of beams swept (≥2); index width `BW = $clog2(NUM_BEAMS)`
- `DATA_W`, 16, width of beamformer output sample (two's complement)
- `DWELL_W`, 16, width of dwell length
- `ACC_W`, 32, metric accumulator width (≥ `DATA_W`+1)
- `TIMEOUT`, 64, weight-load ack timeout in cycles (used only with macro)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  sweep request; sampled only in IDLE
- `dwell_len`  in  `DWELL_W`  samples per beam; latched on accepted `start`
- `sample_valid`  in  1  beamformer output valid
- `sample_in`  in  `DATA_W`  beamformer `data_out`
- `wload_req`  out  1  request weight load for `beam_idx`
- `wload_ack`  in  1  weight path done
- `beam_idx`  out  `BW`  current beam
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse at sweep end
- `best_beam`  out  `BW`  index of highest metric of last sweep
- `best_metric`  out  `ACC_W`  metric of `best_beam`
- `err`  out  1  sticky: a beam was skipped on timeout (cleared on accepted `start`)

## Operation
- FSM states and transitions:
  - IDLE → LOAD on `start`.
  - LOAD → DWELL on `wload_ack`.
  - DWELL → CMP when the count reaches the latched length.
  - CMP → LOAD (next beam) or DONE (last beam).
  - DONE → IDLE.
- Accepted `start`:
  - latches `dwell_len`; a value of 0 is treated as 1;
  - clears `beam_idx`, the running best and `err`;
  - raises `busy`.
- LOAD:
  - `wload_req`=1 while in LOAD.
  - `wload_ack` outside LOAD is ignored.
- DWELL:
  - On each `sample_valid`, `acc += |sample_in|`; −2^(DATA_W−1) maps to +2^(DATA_W−1).
  - `acc` saturates at 2^ACC_W−1.
  - The sample counter counts only valid samples.
- CMP:
  - If `acc` is strictly greater than the running best, or this is beam 0, the running best becomes (`beam_idx`, `acc`). Ties keep the lower index.
  - `acc` and the sample counter are cleared.
  - `beam_idx` increments, or the FSM goes to DONE if `beam_idx`==`NUM_BEAMS`−1.
- DONE:
  - copies the running best to `best_beam`/`best_metric`;
  - `done`=1 and `busy`=0 for that cycle.
- `best_beam`/`best_metric` hold until the next DONE.
- `start` while busy is ignored. `start` held high causes back-to-back sweeps, with one IDLE cycle between them.

## Timing
- Reset values: state IDLE, `wload_req`=0, `beam_idx`=0, `busy`=0, `done`=0, `best_beam`=0, `best_metric`=0, `err`=0, `acc`=0.
- A reset mid-sweep aborts the sweep in the same edge and leaves no partial results.
- `start` high at edge N: `busy`=1 and `wload_req`=1 with `beam_idx`=0 from N+1.
- `wload_ack` high at edge M (in LOAD): `wload_req`=0 from M+1, and DWELL accepts samples from M+1 on. A sample valid in the ack cycle is not counted.
- The edge that counts the `dwell_len`-th valid sample leads to CMP; the next edge enters LOAD or DONE. Further samples in CMP are ignored.
- Per-beam overhead: LOAD (≥1 cycle) + CMP (1 cycle).
- Sweep latency with immediate ack and continuous valid: `NUM_BEAMS`×(`dwell_len`+2)+1 cycles from `start` to `done`.

## Configuration
- `BEAM_SWEEP_CTRL_TIMEOUT_EN` defined:
  - A counter runs in LOAD. After `TIMEOUT` cycles without ack, the beam is skipped: its metric is not compared, `err` is set, and the FSM moves straight to CMP-advance.
  - If all beams are skipped, `best_metric`=0 and `best_beam`=0.
- Not defined:
  - LOAD waits indefinitely.
  - `err` is tied to 0 and no timeout counter is built.

## Test plan
- Reset mid-DWELL of beam 3 → next cycle `busy`=0, `wload_req`=0, `beam_idx`=0, `best_metric`=0.
- `dwell_len`=4, immediate ack, beam k fed constant `sample_in`=100×k → `done` at cycle 8×6+1=49; `best_beam`=7, `best_metric`=2800.
- Beam 2 and beam 5 both give metric 4000 (max), `sample_in`=−1000 ×4 → `best_beam`=2. Also check saturation: `ACC_W`=17, `DATA_W`=16, feeding −32768 ×4 → metric 131071.
- `dwell_len`=0 with `sample_valid` toggling 1-0-1 → each beam counts exactly 1 sample. `start` pulsed during the sweep is ignored. `wload_ack` pulsed in DWELL has no effect.
- With `BEAM_SWEEP_CTRL_TIMEOUT_EN`, `TIMEOUT`=64, beam 4 never acked → LOAD exits after 64 cycles, `err`=1, beam 4 is excluded even when it would be the largest, and `err` clears on the next `start`.

Source files
------------

// File: rtl/beam_sweep_ctrl.sv
// rtl/beam_sweep_ctrl.sv - beam sweep sequencer: weight-load handshake, per-beam magnitude dwell, best-beam pick.
// Optional macro BEAM_SWEEP_CTRL_TIMEOUT_EN adds a weight-load ack timeout that skips the beam and sets err.
module beam_sweep_ctrl #(
    parameter int NUM_BEAMS = 8,
    parameter int DATA_W    = 16,
    parameter int DWELL_W   = 16,
    parameter int ACC_W     = 32,
    parameter int TIMEOUT   = 64,
    localparam int BW       = $clog2(NUM_BEAMS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell_len,
    input  logic               sample_valid,
    input  logic [DATA_W-1:0]  sample_in,
    output logic               wload_req,
    input  logic               wload_ack,
    output logic [BW-1:0]      beam_idx,
    output logic               busy,
    output logic               done,
    output logic [BW-1:0]      best_beam,
    output logic [ACC_W-1:0]   best_metric,
    output logic               err
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DWELL, S_CMP, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [DWELL_W-1:0] r_dwell, r_cnt;
    logic [ACC_W-1:0]   r_acc, r_run_metric, r_best_metric;
    logic [BW-1:0]      r_beam, r_run_beam, r_best_beam;

    logic [DATA_W:0]    w_abs;
    logic [ACC_W:0]     w_sum;
    logic [ACC_W-1:0]   w_acc_next, w_new_metric;
    logic [BW-1:0]      w_new_beam;
    logic               w_last_sample, w_last_beam, w_update, w_timeout, w_skip;

    // Magnitude is one bit wider so the most negative sample maps to +2^(DATA_W-1).
    assign w_abs         = sample_in[DATA_W-1] ? ({1'b0, ~sample_in} + 1'b1) : {1'b0, sample_in};
    assign w_sum         = {1'b0, r_acc} + {{(ACC_W-DATA_W){1'b0}}, w_abs};
    assign w_acc_next    = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
    assign w_last_sample = ({1'b0, r_cnt} + 1'b1) == {1'b0, r_dwell};
    assign w_last_beam   = (r_beam == BW'(NUM_BEAMS - 1));
    assign w_update      = !w_skip && ((r_acc > r_run_metric) || (r_beam == '0));
    assign w_new_beam    = w_update ? r_beam : r_run_beam;
    assign w_new_metric  = w_update ? r_acc  : r_run_metric;

`ifdef BEAM_SWEEP_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_skip, r_err;

    assign w_timeout = (r_state == S_LOAD) && !wload_ack && (r_to_cnt == TO_W'(TIMEOUT - 1));
    assign w_skip    = r_skip;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_skip   <= 1'b0;
            r_err    <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_to_cnt <= '0;
            r_skip   <= 1'b0;
            r_err    <= 1'b0;
        end else if (r_state == S_LOAD) begin
            if (w_timeout) begin
                r_to_cnt <= '0;
                r_skip   <= 1'b1;
                r_err    <= 1'b1;
            end else if (wload_ack) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end else if (r_state == S_CMP) begin
            r_skip <= 1'b0;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_skip    = 1'b0;
    assign err       = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        wload_req = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD: begin
                wload_req = 1'b1;
                busy      = 1'b1;
                if (wload_ack)      w_next = S_DWELL;
                else if (w_timeout) w_next = S_CMP;
            end
            S_DWELL: begin
                busy = 1'b1;
                if (sample_valid && w_last_sample) w_next = S_CMP;
            end
            S_CMP: begin
                busy   = 1'b1;
                w_next = w_last_beam ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell       <= '0;
            r_cnt         <= '0;
            r_acc         <= '0;
            r_beam        <= '0;
            r_run_beam    <= '0;
            r_run_metric  <= '0;
            r_best_beam   <= '0;
            r_best_metric <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_dwell      <= (dwell_len == '0) ? DWELL_W'(1) : dwell_len;
                    r_cnt        <= '0;
                    r_acc        <= '0;
                    r_beam       <= '0;
                    r_run_beam   <= '0;
                    r_run_metric <= '0;
                end
                S_DWELL: if (sample_valid) begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_CMP: begin
                    r_run_beam   <= w_new_beam;
                    r_run_metric <= w_new_metric;
                    r_acc        <= '0;
                    r_cnt        <= '0;
                    // Results publish on the edge into DONE so they are valid alongside the done pulse.
                    if (w_last_beam) begin
                        r_best_beam   <= w_new_beam;
                        r_best_metric <= w_new_metric;
                    end else begin
                        r_beam <= r_beam + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign beam_idx    = r_beam;
    assign best_beam   = r_best_beam;
    assign best_metric = r_best_metric;

endmodule

// File: tb/tb_beam_sweep_ctrl.sv
// tb/tb_beam_sweep_ctrl.sv - randomized scoreboard bench for beam_sweep_ctrl.
module tb_beam_sweep_ctrl;
    localparam int  NB   = 8;
    localparam int  DW   = 16;
    localparam int  LW   = 16;
    localparam int  AW   = 17;
    localparam int  TO   = 64;
    localparam int  BW   = 3;
    localparam longint MAXM = (longint'(1) << AW) - 1;

    logic          clk = 1'b0;
    logic          rst, start, sample_valid, wload_ack;
    logic [LW-1:0] dwell_len;
    logic [DW-1:0] sample_in;
    logic          wload_req, busy, done, err;
    logic [BW-1:0] beam_idx, best_beam;
    logic [AW-1:0] best_metric;

    beam_sweep_ctrl #(.NUM_BEAMS(NB), .DATA_W(DW), .DWELL_W(LW), .ACC_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .dwell_len(dwell_len),
        .sample_valid(sample_valid), .sample_in(sample_in),
        .wload_req(wload_req), .wload_ack(wload_ack), .beam_idx(beam_idx),
        .busy(busy), .done(done), .best_beam(best_beam), .best_metric(best_metric), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     bb;
        longint bm;
        bit     be;
        int     lat;
        int     c0;
    } exp_t;

    exp_t   q[$];
    int     nchk = 0;
    int     nerr = 0;
    int     smp[NB][16];
    int     cur_bb = 0;
    longint cur_bm = 0;

    task automatic chk(input string name, input longint act, input longint req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic summary();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    endtask

    task automatic abort(input string name);
        nerr++;
        $display("FAIL %s timed out waiting for DUT", name);
        summary();
    endtask

    task automatic wait_req();
        for (int i = 0; i < 300; i++) begin
            if (wload_req) return;
            @(negedge clk);
        end
        abort("wload_req_wait");
    endtask

    // mode: 0 random, 1 beam k = 100*k, 2 tie on beams 2/5, 3 most-negative sample everywhere
    task automatic sweep(input int L, input int mode, input bit imm, input bit gaps,
                         input int skip, input int rst_beam);
        int     le;
        int     n;
        int     i;
        longint m;
        logic [15:0] r16;
        exp_t   e;
        le = (L == 0) ? 1 : L;
        for (int k = 0; k < NB; k++)
            for (int j = 0; j < le; j++) begin
                case (mode)
                    0: begin r16 = 16'($urandom); smp[k][j] = int'($signed(r16)); end
                    1: smp[k][j] = 100 * k;
                    2: smp[k][j] = (k == 2 || k == 5) ? -1000 : 50 * k;
                    default: smp[k][j] = -32768;
                endcase
            end
        e.bb = 0; e.bm = 0;
        for (int k = 0; k < NB; k++) begin
            if (k == skip) continue;
            m = 0;
            for (int j = 0; j < le; j++) m += (smp[k][j] < 0) ? -smp[k][j] : smp[k][j];
            if (m > MAXM) m = MAXM;
            if (k == 0 || m > e.bm) begin e.bb = k; e.bm = m; end
        end
        e.be  = (skip >= 0);
        e.lat = (imm && !gaps && skip < 0) ? NB * (le + 2) + 1 : -1;
        e.c0  = cyc;

        chk("hold_best_beam", best_beam, cur_bb);
        chk("hold_best_metric", best_metric, cur_bm);
        q.push_back(e);
        dwell_len = LW'(L);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_wload_req", wload_req, 1);
        chk("start_beam_idx", beam_idx, 0);
        chk("start_err_clear", err, 0);

        for (int k = 0; k < NB; k++) begin
            wait_req();
            chk("beam_idx", beam_idx, k);
            if (k == skip) begin
                n = 0;
                while (wload_req && n < 300) begin n++; @(negedge clk); end
                chk("timeout_cycles", n, TO);
                continue;
            end
            if (!imm) repeat ($urandom_range(1, 3)) @(negedge clk);
            wload_ack = 1'b1; sample_valid = 1'b1; sample_in = 16'h7fff;
            @(negedge clk);
            wload_ack = 1'b0;
            i = 0;
            while (i < le) begin
                if (k == rst_beam && i == 2) begin
                    rst = 1'b1; sample_valid = 1'b0;
                    @(negedge clk);
                    chk("rst_busy", busy, 0);
                    chk("rst_wload_req", wload_req, 0);
                    chk("rst_beam_idx", beam_idx, 0);
                    chk("rst_best_metric", best_metric, 0);
                    chk("rst_best_beam", best_beam, 0);
                    chk("rst_done", done, 0);
                    rst = 1'b0;
                    void'(q.pop_back());
                    cur_bb = 0; cur_bm = 0;
                    @(negedge clk);
                    return;
                end
                sample_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                if (gaps) begin
                    wload_ack = ($urandom_range(0, 3) == 0);
                    start     = ($urandom_range(0, 3) == 0);
                end
                sample_in = sample_valid ? DW'(smp[k][i]) : DW'($urandom);
                @(negedge clk);
                if (sample_valid) i++;
            end
            wload_ack = 1'b0; start = 1'b0;
            sample_valid = 1'b1; sample_in = 16'h8000;
            @(negedge clk);
            sample_valid = 1'b0;
        end
        n = 0;
        while ((busy || done) && n < 300) begin n++; @(negedge clk); end
        if (n >= 300) abort("sweep_end_wait");
        cur_bb = e.bb; cur_bm = e.bm;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("best_beam", best_beam, e.bb);
                    chk("best_metric", best_metric, e.bm);
                    chk("err", err, e.be);
                    chk("done_busy_low", busy, 0);
                    if (e.lat >= 0) chk("sweep_latency", cyc - e.c0, e.lat);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        abort("global_watchdog");
    end

    initial begin : driver
        rst = 1'b1; start = 1'b0; dwell_len = '0; sample_valid = 1'b0;
        sample_in = '0; wload_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_wload_req", wload_req, 0);
        chk("reset_beam_idx", beam_idx, 0);
        chk("reset_done", done, 0);
        chk("reset_best_beam", best_beam, 0);
        chk("reset_best_metric", best_metric, 0);
        chk("reset_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        sweep(4, 1, 1'b1, 1'b0, -1, -1);
        sweep(4, 2, 1'b0, 1'b0, -1, -1);
        sweep(4, 3, 1'b1, 1'b0, -1, -1);
        sweep(0, 0, 1'b0, 1'b1, -1, -1);
        sweep(4, 1, 1'b1, 1'b0, -1, 3);
        for (int t = 0; t < 6; t++)
            sweep($urandom_range(0, 6), 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1);
`ifdef BEAM_SWEEP_CTRL_TIMEOUT_EN
        sweep(4, 1, 1'b1, 1'b0, 4, -1);
        sweep(3, 1, 1'b1, 1'b0, -1, -1);
`endif
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        summary();
    end
endmodule
